buffer_fifo: RTL and testbench

- Parametrised synchronous FIFO. It is the registered successor to the combinational buffer pointer controller.
- Owns its storage array, pointers and occupancy counter.
- Adds configurable data width, an almost-full threshold, a synchronous flush, and sticky overflow/underflow flags.
- Used between TCU pipeline stages wherever a push/pop instruction or operand queue is needed.

---
 rtl/buffer_pkg.sv | 20 ++
 rtl/buffer_fifo_mem.sv | 29 ++
 rtl/buffer_fifo.sv | 140 ++++++++++++++
 tb/tb_buffer_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared definitions for buffer_fifo: depth/count-width helpers and the
// {push,pop} operation encoding used by the pointer update.
package buffer_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

   function automatic int DEPTH(input int addr_bw);
      return 2 ** addr_bw;
   endfunction

   function automatic int CNT_BW(input int addr_bw);
      return addr_bw + 1;
   endfunction

endpackage

// File: rtl/buffer_fifo_mem.sv
// DATA_BW x 2**ADDR_BW register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module buffer_fifo_mem
   import buffer_pkg::*;
#(
   parameter int DATA_BW = 8,
   parameter int ADDR_BW = 2
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [ADDR_BW-1:0] waddr_i,
   input  logic [DATA_BW-1:0] wdata_i,
   input  logic [ADDR_BW-1:0] raddr_i,
   output logic [DATA_BW-1:0] rdata_o
);

   localparam int DEPTH_C = DEPTH(ADDR_BW);

   logic [DATA_BW-1:0] mem_q [DEPTH_C];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/buffer_fifo.sv
// Registered synchronous FIFO with show-ahead read, flush and sticky error flags.
// Optional peak-occupancy output enabled by defining BUFFER_FIFO_WATERMARK_EN.
module buffer_fifo
   import buffer_pkg::*;
#(
   parameter int DATA_BW  = 8,
   parameter int ADDR_BW  = 2,
   parameter int AFULL_TH = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               wr_din,
   input  logic [DATA_BW-1:0] wr_data,
   input  logic               rd_dout,
   output logic [DATA_BW-1:0] rd_data,
   output logic               push_ack,
   output logic               pop_ack,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
   output logic [ADDR_BW:0]   num_item,
   output logic               ovf_err,
   output logic               udf_err
`ifdef BUFFER_FIFO_WATERMARK_EN
   ,
   output logic [ADDR_BW:0]   max_item
`endif
);

   localparam int               CNT_W   = CNT_BW(ADDR_BW);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH(ADDR_BW));
   localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

   logic [ADDR_BW-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               udf_q, udf_d;
   logic [DATA_BW-1:0] mem_rdata;
   op_e                op;

   assign full        = (cnt_q == DEPTH_C);
   assign empty       = (cnt_q == '0);
   assign almost_full = (cnt_q >= AFULL_C);
   assign num_item    = cnt_q;
   assign ovf_err     = ovf_q;
   assign udf_err     = udf_q;

   // Acceptance looks only at registered occupancy: no pass-through when
   // full and no read-through when empty.
   assign push_ack = wr_din & ~full & ~flush;
   assign pop_ack  = rd_dout & ~empty & ~flush;
   assign op       = op_e'({push_ack, pop_ack});

   buffer_fifo_mem #(
      .DATA_BW (DATA_BW),
      .ADDR_BW (ADDR_BW)
   ) u_mem (
      .clk     (clk),
      .we_i    (push_ack),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

   assign rd_data = empty ? '0 : mem_rdata;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q | (wr_din & full);
      udf_d    = udf_q | (rd_dout & empty);
      case (op)
         OP_PUSH: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
         end
         OP_POP: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q - 1'b1;
         end
         OP_BOTH: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         default: ;
      endcase
      // Flush overrides everything, including error flags set this cycle.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef BUFFER_FIFO_WATERMARK_EN
   logic [CNT_W-1:0] max_q, max_d;

   always_comb begin
      max_d = max_q;
      if (flush) begin
         max_d = '0;
      end else if (cnt_d > max_q) begin
         max_d = cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign max_item = max_q;
`endif

endmodule

// File: tb/tb_buffer_fifo.sv
// Self-checking bench for buffer_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_buffer_fifo;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DEPTH = 4;
   localparam int AFTH = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          wr_din;
   logic [DW-1:0] wr_data;
   logic          rd_dout;
   logic [DW-1:0] rd_data;
   logic          push_ack;
   logic          pop_ack;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic [AW:0]   num_item;
   logic          ovf_err;
   logic          udf_err;
`ifdef BUFFER_FIFO_WATERMARK_EN
   logic [AW:0]   max_item;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] q[$];
   bit         m_ovf;
   bit         m_udf;
   int         m_peak;

   always #5 clk = ~clk;

   buffer_fifo #(
      .DATA_BW  (DW),
      .ADDR_BW  (AW),
      .AFULL_TH (AFTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .wr_din      (wr_din),
      .wr_data     (wr_data),
      .rd_dout     (rd_dout),
      .rd_data     (rd_data),
      .push_ack    (push_ack),
      .pop_ack     (pop_ack),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .num_item    (num_item),
      .ovf_err     (ovf_err),
      .udf_err     (udf_err)
`ifdef BUFFER_FIFO_WATERMARK_EN
      ,
      .max_item    (max_item)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_peak = 0;
   endtask

   task automatic check_state(input string pfx);
      int n;
      n = q.size();
      chk({pfx, "_num"},   num_item, n);
      chk({pfx, "_empty"}, empty, n == 0);
      chk({pfx, "_full"},  full, n == DEPTH);
      chk({pfx, "_afull"}, almost_full, n >= AFTH);
      chk({pfx, "_rdata"}, rd_data, (n > 0) ? q[0] : 8'h00);
      chk({pfx, "_ovf"},   ovf_err, m_ovf);
      chk({pfx, "_udf"},   udf_err, m_udf);
`ifdef BUFFER_FIFO_WATERMARK_EN
      chk({pfx, "_max"},   max_item, m_peak);
`endif
   endtask

   // One clock cycle: drive at negedge, check just after, update model at posedge.
   task automatic step(input string pfx, input bit w, input logic [7:0] d,
                       input bit r, input bit f);
      bit exp_push, exp_pop;
      int n;
      @(negedge clk);
      wr_din  = w;
      wr_data = d;
      rd_dout = r;
      flush   = f;
      #1;
      n        = q.size();
      exp_push = w && (n < DEPTH) && !f;
      exp_pop  = r && (n > 0) && !f;
      chk({pfx, "_push_ack"}, push_ack, exp_push);
      chk({pfx, "_pop_ack"},  pop_ack,  exp_pop);
      check_state(pfx);
      @(posedge clk);
      if (f) begin
         model_clear();
      end else begin
         if (w && n == DEPTH) m_ovf = 1'b1;
         if (r && n == 0)     m_udf = 1'b1;
         if (exp_pop)  void'(q.pop_front());
         if (exp_push) q.push_back(d);
         if (q.size() > m_peak) m_peak = q.size();
      end
   endtask

   // Assert reset between clock edges and confirm outputs clear without an edge.
   task automatic async_reset(input string pfx);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_state(pfx);
      wr_din  = 1'b0;
      rd_dout = 1'b0;
      flush   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      wr_din  = 1'b0;
      wr_data = '0;
      rd_dout = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      check_state("rst_init");
      rst = 1'b0;

      // T1: fill to full
      step("t1", 1'b1, 8'h11, 1'b0, 1'b0);
      step("t1", 1'b1, 8'h22, 1'b0, 1'b0);
      step("t1", 1'b1, 8'h33, 1'b0, 1'b0);
      #1;
      chk("t1_afull3", almost_full, 1'b1);
      step("t1", 1'b1, 8'h44, 1'b0, 1'b0);
      #1;
      chk("t1_full4", full, 1'b1);
      chk("t1_num4", num_item, 3'd4);
      chk("t1_rd11", rd_data, 8'h11);
`ifdef BUFFER_FIFO_WATERMARK_EN
      chk("t1_max4", max_item, 3'd4);
`endif

      // T2: push+pop while full
      step("t2", 1'b1, 8'h55, 1'b1, 1'b0);
      #1;
      chk("t2_num3", num_item, 3'd3);
      chk("t2_ovf", ovf_err, 1'b1);
      chk("t2_rd22", rd_data, 8'h22);

      // T3: push+pop while empty
      async_reset("t3_rst");
      step("t3", 1'b1, 8'hA5, 1'b1, 1'b0);
      #1;
      chk("t3_num1", num_item, 3'd1);
      chk("t3_rdA5", rd_data, 8'hA5);
      chk("t3_udf", udf_err, 1'b1);

      // T4: steady push+pop with one entry preloaded, pointers wrap
      for (int i = 0; i < 10; i++) begin
         step("t4", 1'b1, 8'($urandom), 1'b1, 1'b0);
      end
      #1;
      chk("t4_num1", num_item, 3'd1);

      // T5: flush with ovf set and three entries
      step("t5", 1'b1, 8'h61, 1'b0, 1'b0);
      step("t5", 1'b1, 8'h62, 1'b0, 1'b0);
      step("t5", 1'b1, 8'h63, 1'b0, 1'b0);
      step("t5", 1'b1, 8'h64, 1'b0, 1'b0);
      step("t5", 1'b0, 8'h00, 1'b1, 1'b0);
      step("t5f", 1'b1, 8'h77, 1'b0, 1'b1);
      #1;
      chk("t5_empty", empty, 1'b1);
      chk("t5_num0", num_item, 3'd0);
      chk("t5_ovf0", ovf_err, 1'b0);
      chk("t5_rd0", rd_data, 8'h00);

      // T6: async reset mid-burst
      step("t6", 1'b1, 8'h81, 1'b0, 1'b0);
      step("t6", 1'b1, 8'h82, 1'b1, 1'b0);
      wr_din = 1'b1;
      async_reset("t6_rst");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step("rnd", $urandom_range(0, 99) < 60, 8'($urandom),
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
         if (i == 300) async_reset("rnd_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
